// File: rtl/mux4_bus_arbiter_if.sv
// Handshake/bus bundle between four requesters, the mux arbiter and the downstream consumer.
// master = arbiter side; slave = requesters plus consumer.
interface mux4_bus_arbiter_if;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [15:0] req_data2;
  logic [15:0] req_data3;
  logic [3:0]  req_ready;
  logic [1:0]  mux_select;
  logic [3:0]  grant;
  logic        busy;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;

  modport master (
    input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    output req_ready, mux_select, grant, busy, out_valid, out_data, out_last, out_src
  );

  modport slave (
    output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    input  req_ready, mux_select, grant, busy, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/mux4_bus_arbiter.sv
// Round-robin packet arbiter for a 4:1 16-bit mux feeding one registered valid/ready output stage.
// Grant one cycle after request, first beat out one cycle later; req_ready drops while the output slot is full and stalled.
module mux4_bus_arbiter #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input logic          clk,
  input logic          reset,
  mux4_bus_arbiter_if.master bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             ov_q;
  logic [15:0]      od_q;
  logic             ol_q;
  logic [1:0]       os_q;

  logic [1:0]       winner;
  logic [1:0]       arb_idx;
  logic             arb_found;
  logic [15:0]      mux_dat;
  logic             slot_free;
  logic [3:0]       ready;
  logic             xfer;
  logic             beat_last;

  // Scan from rr_ptr upward so the previous winner ends up lowest priority.
  always_comb begin
    winner    = rr_ptr;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arb_idx = rr_ptr + 2'(i);
      if (!arb_found && bus.req_valid[arb_idx]) begin
        winner    = arb_idx;
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    mux_dat = '0;
    case (sel_q)
      2'd0:    mux_dat = bus.req_data0;
      2'd1:    mux_dat = bus.req_data1;
      2'd2:    mux_dat = bus.req_data2;
      default: mux_dat = bus.req_data3;
    endcase
  end

  assign slot_free = !ov_q || bus.out_ready;
  assign ready     = (state == BUSY && slot_free) ? (4'b0001 << sel_q) : 4'b0000;
  assign xfer      = |(ready & bus.req_valid);
  assign beat_last = bus.req_last[sel_q] || (beat_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ol_q     <= 1'b0;
      os_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state    <= BUSY;
            grant_q  <= 4'b0001 << winner;
            sel_q    <= winner;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (beat_last) begin
              state    <= IDLE;
              grant_q  <= '0;
              rr_ptr   <= sel_q + 2'd1;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A new beat overwrites the slot even when the old one is being accepted this cycle.
      if (xfer) begin
        ov_q <= 1'b1;
        od_q <= mux_dat;
        ol_q <= beat_last;
        os_q <= sel_q;
      end else if (bus.out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.mux_select = sel_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state == BUSY);
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign bus.out_last   = ol_q;
  assign bus.out_src    = os_q;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Bench for mux4_bus_arbiter: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based packet/arbitration model.
module tb_mux4_bus_arbiter;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux4_bus_arbiter_if bus();

  mux4_bus_arbiter #(.MAX_BEATS(MAXB), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [1:0]  s;
  } beat_t;

  typedef struct packed {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        ordy;
    logic [15:0] dat;
    logic [3:0]  e_grant;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_dat;
    logic        e_last;
    logic [1:0]  e_src;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Model: owner of the mux (-1 idle), rotation pointer, beats accepted this grant, beats in flight.
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [1:0] m_sel = 2'd0;
  beat_t      m_pend[$];
  logic [3:0] acc;
  logic [15:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0]  vld, lst, erdy;
    logic        ordy, rst, found;
    logic [15:0] d[4];
    beat_t       b;
    #2;
    vld  = bus.req_valid;
    lst  = bus.req_last;
    ordy = bus.out_ready;
    rst  = reset;
    d[0] = bus.req_data0; d[1] = bus.req_data1; d[2] = bus.req_data2; d[3] = bus.req_data3;
    erdy = '0;
    if (m_owner >= 0 && (m_pend.size() == 0 || ordy)) erdy[m_owner] = 1'b1;
    if (!rst) chk("req_ready", bus.req_ready, erdy);
    acc = erdy & vld;
    if (!rst && bus.out_valid && ordy) got.push_back(bus.out_data);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 2'd0; acc = '0;
      m_pend.delete();
    end else begin
      if (ordy && m_pend.size() > 0) void'(m_pend.pop_front());
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && vld[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        if (found) begin
          m_cnt = 0;
          m_sel = 2'(m_owner);
        end
      end else if (acc != 0) begin
        m_cnt++;
        b.d = d[m_owner];
        b.s = 2'(m_owner);
        b.l = lst[m_owner] || (m_cnt == MAXB);
        m_pend.push_back(b);
        if (b.l) begin
          m_ptr = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end
    end
    #1;
    chk("grant", bus.grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("busy", bus.busy, (m_owner >= 0) ? 1 : 0);
    chk("mux_select", bus.mux_select, m_sel);
    chk("out_valid", bus.out_valid, (m_pend.size() != 0) ? 1 : 0);
    if (m_pend.size() != 0) begin
      chk("out_data", bus.out_data, m_pend[0].d);
      chk("out_last", bus.out_last, m_pend[0].l);
      chk("out_src", bus.out_src, m_pend[0].s);
    end
  endtask

  task automatic set_in(input logic [3:0] vld, input logic [3:0] lst, input logic ordy);
    bus.req_valid = vld;
    bus.req_last  = lst;
    bus.out_ready = ordy;
  endtask

  vec_t tv[$];
  int sent, nobs, nlast, gap, c2;
  logic [15:0] held;
  logic done3, in_gap, r1v;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // T1: single 3-beat packet from requester 0, then rr_ptr=1 picks requester 1 over 0 and 3.
    tv.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 16'h1111, 4'b0001, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 16'h1111, 4'b0001, 4'b0001, 1'b1, 16'h1111, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 16'h2222, 4'b0001, 4'b0001, 1'b1, 16'h2222, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 16'h3333, 4'b0000, 4'b0000, 1'b1, 16'h3333, 1'b1, 2'd0});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1011, 4'b1111, 1'b1, 16'h5550, 4'b0010, 4'b0010, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1011, 4'b1111, 1'b1, 16'h5550, 4'b0000, 4'b0000, 1'b1, 16'h5551, 1'b1, 2'd1});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0});
    // T2: all four with 1-beat packets, data 0xA000+i; grant rotates 0,1,2,3,0.
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0001, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0000, 4'b0000, 1'b1, 16'hA000, 1'b1, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0010, 4'b0010, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0000, 4'b0000, 1'b1, 16'hA001, 1'b1, 2'd1});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0100, 4'b0100, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0000, 4'b0000, 1'b1, 16'hA002, 1'b1, 2'd2});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b1000, 4'b1000, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0000, 4'b0000, 1'b1, 16'hA003, 1'b1, 2'd3});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0001, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0});
    tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'hA000, 4'b0000, 4'b0000, 1'b1, 16'hA000, 1'b1, 2'd0});

    reset = 1'b1;
    set_in(4'b0, 4'b0, 1'b0);
    bus.req_data0 = '0; bus.req_data1 = '0; bus.req_data2 = '0; bus.req_data3 = '0;
    tick();
    tick();
    chk("rst_out_data", bus.out_data, 16'h0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_src", bus.out_src, 2'd0);
    chk("rst_req_ready", bus.req_ready, 4'b0);
    reset = 1'b0;

    foreach (tv[i]) begin
      reset = tv[i].rst;
      set_in(tv[i].vld, tv[i].lst, tv[i].ordy);
      bus.req_data0 = tv[i].dat;
      bus.req_data1 = tv[i].dat + 16'd1;
      bus.req_data2 = tv[i].dat + 16'd2;
      bus.req_data3 = tv[i].dat + 16'd3;
      tick();
      chk($sformatf("tv%0d_grant", i), bus.grant, tv[i].e_grant);
      chk($sformatf("tv%0d_rdy", i), bus.req_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_ov", i), bus.out_valid, tv[i].e_ov);
      if (tv[i].e_ov) begin
        chk($sformatf("tv%0d_dat", i), bus.out_data, tv[i].e_dat);
        chk($sformatf("tv%0d_last", i), bus.out_last, tv[i].e_last);
        chk($sformatf("tv%0d_src", i), bus.out_src, tv[i].e_src);
      end
    end
    reset = 1'b0;

    // T3: requester 2 streams 20 beats without last; release forced on beat 16.
    set_in(4'b0, 4'b0, 1'b1);
    tick();
    sent = 0; nobs = 0; nlast = 0;
    for (int c = 0; c < 60; c++) begin
      bus.req_data2 = 16'h2000 + 16'(sent);
      set_in((sent < 20) ? 4'b0100 : 4'b0000, 4'b0000, 1'b1);
      tick();
      if (acc[2]) sent++;
      if (bus.out_valid) begin
        nobs++;
        if (bus.out_last) nlast++;
        if (nobs == 16) begin
          chk("t3_b16_last", bus.out_last, 1'b1);
          chk("t3_b16_grant", bus.grant, 4'b0000);
        end
        if (nobs == 17) chk("t3_b17_data", bus.out_data, 16'h2010);
      end
    end
    chk("t3_sent", sent, 20);
    chk("t3_obs", nobs, 20);
    chk("t3_nlast", nlast, 1);
    chk("t3_regrant", bus.grant, 4'b0100);

    // T4: 8-beat packet from requester 0 with out_ready low for 5 cycles mid-packet.
    reset = 1'b1;
    set_in(4'b0, 4'b0, 1'b1);
    tick();
    reset = 1'b0;
    got.delete();
    sent = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      bus.req_data0 = 16'h4000 + 16'(sent);
      set_in((sent < 8) ? 4'b0001 : 4'b0000, (sent == 7) ? 4'b0001 : 4'b0000, !(c >= 4 && c < 9));
      tick();
      if (acc[0]) sent++;
      if (c == 4) begin
        held = bus.out_data;
        chk("t4_held", held, 16'h4002);
      end
      if (c > 4 && c < 9) begin
        chk("t4_stall_ov", bus.out_valid, 1'b1);
        chk("t4_stall_dat", bus.out_data, held);
        chk("t4_stall_rdy", bus.req_ready, 4'b0000);
      end
    end
    chk("t4_count", got.size(), 8);
    foreach (got[k]) chk($sformatf("t4_beat%0d", k), got[k], 16'h4000 + 16'(k));

    // T5: requester 1 pauses 3 cycles mid-packet while requester 3 waits.
    got.delete();
    sent = 0; gap = 0; done3 = 1'b0;
    bus.req_data3 = 16'h5300;
    for (int c = 0; c < 40; c++) begin
      in_gap = (sent == 2 && gap < 3);
      r1v = (sent < 6) && !in_gap;
      bus.req_data1 = 16'h5100 + 16'(sent);
      set_in({!done3, 1'b0, r1v, 1'b0}, {1'b1, 1'b0, (sent == 5), 1'b0}, 1'b1);
      tick();
      if (in_gap) begin
        gap++;
        chk("t5_gap_grant", bus.grant, 4'b0010);
      end
      if (acc[1]) sent++;
      if (acc[3]) done3 = 1'b1;
      if (bus.out_valid && bus.out_src == 2'd3) chk("t5_r3_after_r1", sent, 6);
    end
    chk("t5_done3", done3, 1'b1);
    chk("t5_beats", got.size(), 7);

    // T6: reset while busy with a held beat, then rr_ptr must be back at 0.
    bus.req_data1 = 16'h6100;
    set_in(4'b0010, 4'b0010, 1'b1);
    tick();
    tick();
    bus.req_data2 = 16'h6200;
    set_in(4'b0100, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    chk("t6_pre_ov", bus.out_valid, 1'b1);
    reset = 1'b1;
    set_in(4'b0000, 4'b0000, 1'b1);
    tick();
    reset = 1'b0;
    chk("t6_grant", bus.grant, 4'b0000);
    chk("t6_ov", bus.out_valid, 1'b0);
    chk("t6_dat", bus.out_data, 16'h0000);
    chk("t6_busy", bus.busy, 1'b0);
    bus.req_data0 = 16'h6A00;
    set_in(4'b0101, 4'b0101, 1'b1);
    tick();
    chk("t6_regrant", bus.grant, 4'b0001);
    tick();
    chk("t6_beat_dat", bus.out_data, 16'h6A00);
    chk("t6_beat_src", bus.out_src, 2'd0);

    // Random traffic; alternate short and long packet regimes to exercise forced release.
    c2 = 0;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.req_valid = 4'($urandom);
      for (int k = 0; k < 4; k++)
        bus.req_last[k] = (((c / 250) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.req_data0 = 16'($urandom);
      bus.req_data1 = 16'($urandom);
      bus.req_data2 = 16'($urandom);
      bus.req_data3 = 16'($urandom);
      tick();
      c2++;
    end
    reset = 1'b0;
    set_in(4'b0, 4'b0, 1'b1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux4_bus_arbiter.md
Name: mux4_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 16-bit datapath mux.
- Four requesters each present a 16-bit packet stream; the block grants the mux to one requester at a time and drives the mux select.
- Granted beats are moved through a registered valid/ready output stage to the single downstream consumer.
- Grant is held per packet, until `req_last` or until a beat-count limit is reached.

Parameters:
- MAX_BEATS, 16, maximum beats per grant before release is forced (≥1).
- CNT_W, 5, beat counter width; must hold MAX_BEATS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester beat valid.
- req_last  in  4  per-requester end-of-packet flag, qualified by req_valid.
- req_data0  in  16  requester 0 data.
- req_data1  in  16  requester 1 data.
- req_data2  in  16  requester 2 data.
- req_data3  in  16  requester 3 data.
- req_ready  out  4  per-requester beat accept (one-hot or zero).
- mux_select  out  2  select driven to the 4:1 mux; equals the granted index.
- grant  out  4  one-hot current grant; zero when idle.
- busy  out  1  high while in BUSY.
- out_valid  out  1  output beat valid.
- out_data  out  16  output beat data.
- out_last  out  1  output beat ends the packet (native last or forced).
- out_src  out  2  index of the requester that produced out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - state=IDLE, grant=0, mux_select=0, rr_ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - req_ready=0, busy=0.
  - Reset mid-packet abandons the packet and drops any held output beat.
- States: IDLE, BUSY.
- IDLE:
  - req_ready=0.
  - If req_valid≠0, pick the first asserted requester scanning rr_ptr, rr_ptr+1, … (mod 4).
  - Next edge: grant=onehot(winner), mux_select=winner, beat_cnt=0, state=BUSY.
  - No beat is accepted in the arbitration cycle.
- BUSY:
  - Granted index g.
  - req_ready[g] = (!out_valid | out_ready); all other req_ready bits are 0.
  - A beat transfers when req_valid[g] & req_ready[g].
  - On a transfer: out_data ← mux output (req_data_g selected via mux_select), out_src ← g, out_valid ← 1, beat_cnt ← beat_cnt+1.
  - On a transfer: out_last ← req_last[g] | (beat_cnt == MAX_BEATS-1).
  - If the transferred beat has out_last=1: next state=IDLE, grant=0, rr_ptr=(g+1) mod 4, beat_cnt=0.
  - The grant is held while req_valid[g]=0 mid-packet. No timeout on idle cycles; only accepted beats count.
- Output register:
  - If out_ready & out_valid and no new transfer: out_valid ← 0.
  - Simultaneous accept and transfer: the register is overwritten, out_valid stays 1.
  - out_data, out_last and out_src are held stable while out_valid & !out_ready.
- Latency:
  - Request at IDLE cycle N → grant and req_ready at N+1.
  - First beat visible on out_valid at N+2.
  - Sustained throughput of 1 beat/cycle when out_ready=1.
- Back-to-back packets: each packet costs one IDLE arbitration cycle, so there is a 1-cycle bubble between packets.
- Fairness: the last winner becomes lowest priority, so no requester waits more than 3 packets.
- Forced release at MAX_BEATS: the requester's remaining beats are arbitrated as a new packet later.
- busy = (state == BUSY).
- mux_select holds its last granted value while in IDLE.

Test Plan:
1. Reset, then req_valid=4'b0001 with a 3-beat packet (0x1111, 0x2222, 0x3333, last on the third beat) and out_ready=1.
   - grant=0001 one cycle after the request.
   - out_data sequence 0x1111/0x2222/0x3333 on consecutive cycles, out_last only on 0x3333.
   - Then grant=0 and rr_ptr=1.
2. All four requesters assert continuous 1-beat packets (last=1) with data 0xA000+i.
   - Grant order 0,1,2,3,0.
   - out_src follows that order, one packet every 2 cycles.
3. Requester 2 sends 20 beats with req_last never asserted and MAX_BEATS=16.
   - Beat 16 emerges with out_last=1 and the grant is released.
   - Re-arbitration follows; the remaining 4 beats arrive as a new packet.
4. Backpressure: out_ready=0 for 5 cycles mid-packet.
   - out_valid=1 and out_data held constant; req_ready[g]=0.
   - No beat is lost or duplicated after out_ready returns to 1.
5. Requester 1 deasserts req_valid for 3 cycles mid-packet while requester 3 requests.
   - grant stays 0010 and beat_cnt does not advance.
   - Requester 3 is granted only after requester 1's last beat.
6. reset=1 for one cycle while BUSY with out_valid=1.
   - The next cycle shows state IDLE, grant=0, out_valid=0, out_data=0, rr_ptr=0.
   - A new request from requester 0 is granted normally.
